// File: rtl/diff_demo_pkg.sv
// Shared widths and the write-back packer state type.
// The psum buffer depth sets the packer's read address width.
package diff_demo_pkg;

  localparam int PSUM_WIDTH                  = 16;
  localparam int FM_GUARD_GEN_PSUM_BUF_DEPTH = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_GUARD = 3'd3,
    S_EMIT8 = 3'd4,
    S_EMIT4 = 3'd5,
    S_FIN   = 3'd6
  } wbp_state_t;

endpackage

// File: rtl/wbp_lane_quant.sv
// One psum lane: ReLU plus saturation to a byte, and its guard bits.
// Diff mode splits lanes into full-byte (guard8) and nibble-only (guard4) groups.
module wbp_lane_quant #(
  parameter int PSUM_W = 16
) (
  input  logic [PSUM_W-1:0] i_psum,
  input  logic              i_is_diff,
  output logic [7:0]        o_value,
  output logic              o_guard8,
  output logic              o_guard4
);

  logic w_neg;
  logic w_over;

  assign w_neg  = i_psum[PSUM_W-1];
  assign w_over = !w_neg && (|i_psum[PSUM_W-2:8]);

  always_comb begin
    o_value  = i_psum[7:0];
    o_guard8 = 1'b0;
    o_guard4 = 1'b0;
    if (w_neg) begin
      o_value = 8'h00;
    end else if (w_over) begin
      o_value = 8'hFF;
    end
    if (i_is_diff) begin
      o_guard8 = |o_value[7:4];
      o_guard4 = (|o_value[3:0]) && !(|o_value[7:4]);
    end else begin
      o_guard8 = |o_value;
    end
  end

endmodule

// File: rtl/write_back_packer.sv
// Reads psum windows, quantises each lane, emits a guard map and then the
// nonzero bytes (full bytes first, then nibble pairs) highest lane first.
module write_back_packer
  import diff_demo_pkg::*;
#(
  parameter int LANES  = 6,
  parameter int PSUM_W = PSUM_WIDTH,
  parameter int ADDR_W = $clog2(FM_GUARD_GEN_PSUM_BUF_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ctrl_valid,
  output logic                    ctrl_ready,
  output logic                    ctrl_finish,
  input  logic [7:0]              cfg_w_num,
  input  logic [7:0]              cfg_h_num,
  input  logic [7:0]              cfg_w_cut,
  input  logic                    cfg_is_diff,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       addr_o,
  input  logic [LANES*PSUM_W-1:0] data_i,
  output logic [LANES-1:0]        guard_o,
  output logic [LANES-1:0]        guard4_o,
  output logic                    guard_o_valid,
  input  logic                    guard_o_ready,
  output logic [7:0]              data_o,
  output logic                    data_o_packed,
  output logic                    data_o_valid,
  input  logic                    data_o_ready,
  output wbp_state_t              o_dbg_state
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // once valid is high, payload is held and valid stays high until it does.

  wbp_state_t              r_state, w_next;
  logic [7:0]              r_w_num, r_w_cut, r_count_w, r_count_h;
  logic                    r_is_diff;
  logic [ADDR_W-1:0]       r_addr;
  logic [LANES-1:0][7:0]   r_val;
  logic [LANES-1:0]        r_guard, r_guard4, r_mask8, r_mask4;

  logic [LANES-1:0][7:0]   w_val;
  logic [LANES-1:0]        w_guard8, w_guard4, w_rest4;
  logic [IDX_W-1:0]        w_hi8, w_hi4a, w_hi4b;
  logic                    w_last;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    wbp_lane_quant #(.PSUM_W(PSUM_W)) u_quant (
      .i_psum   (data_i[g*PSUM_W +: PSUM_W]),
      .i_is_diff(r_is_diff),
      .o_value  (w_val[g]),
      .o_guard8 (w_guard8[g]),
      .o_guard4 (w_guard4[g])
    );
  end

  // Priority encoder: index of the highest set bit (0 when empty).
  function automatic logic [IDX_W-1:0] f_top_idx(input logic [LANES-1:0] m);
    f_top_idx = '0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) f_top_idx = IDX_W'(i);
    end
  endfunction

  assign addr_o      = r_addr;
  assign o_dbg_state = r_state;

  always_comb begin
    w_next        = r_state;
    ctrl_ready    = 1'b0;
    ctrl_finish   = 1'b0;
    rd_en         = 1'b0;
    guard_o_valid = 1'b0;
    guard_o       = '0;
    guard4_o      = '0;
    data_o_valid  = 1'b0;
    data_o        = '0;
    data_o_packed = 1'b0;
    w_hi8         = f_top_idx(r_mask8);
    w_hi4a        = f_top_idx(r_mask4);
    w_rest4       = r_mask4 & ~(LANES'(1) << w_hi4a);
    w_hi4b        = f_top_idx(w_rest4);
    w_last        = (r_count_w == 8'd0) && (r_count_h == 8'd0);
    case (r_state)
      S_IDLE: begin
        ctrl_ready = 1'b1;
        if (ctrl_valid) begin
          w_next = (cfg_w_num == 8'd0 || cfg_h_num == 8'd0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        rd_en  = 1'b1;
        w_next = S_LOAD;
      end
      S_LOAD: w_next = S_GUARD;
      S_GUARD: begin
        guard_o_valid = 1'b1;
        guard_o       = r_guard;
        guard4_o      = r_guard4;
        if (guard_o_ready) w_next = (r_guard == '0) ? S_EMIT4 : S_EMIT8;
      end
      S_EMIT8: begin
        if (r_mask8 == '0) begin
          w_next = S_EMIT4;
        end else begin
          data_o_valid = 1'b1;
          data_o       = r_val[w_hi8];
        end
      end
      S_EMIT4: begin
        if (r_mask4 == '0) begin
          w_next = w_last ? S_FIN : S_READ;
        end else begin
          data_o_valid  = 1'b1;
          data_o_packed = 1'b1;
          data_o        = {r_val[w_hi4a][3:0],
                           (w_rest4 != '0) ? r_val[w_hi4b][3:0] : 4'h0};
        end
      end
      S_FIN: begin
        ctrl_finish = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_w_num   <= '0;
      r_w_cut   <= '0;
      r_is_diff <= 1'b0;
      r_count_w <= '0;
      r_count_h <= '0;
      r_addr    <= '0;
      r_val     <= '0;
      r_guard   <= '0;
      r_guard4  <= '0;
      r_mask8   <= '0;
      r_mask4   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (ctrl_valid) begin
            r_w_num   <= cfg_w_num;
            r_w_cut   <= cfg_w_cut;
            r_is_diff <= cfg_is_diff;
            r_count_w <= cfg_w_num - 8'd1;
            r_count_h <= cfg_h_num - 8'd1;
            r_addr    <= '0;
          end
        end
        S_READ: begin
          // End of a row jumps over the cut region of the buffer.
          if (r_count_w == 8'd0) r_addr <= r_addr + ADDR_W'(r_w_cut) + ADDR_W'(1);
          else                   r_addr <= r_addr + ADDR_W'(1);
        end
        S_LOAD: begin
          r_val    <= w_val;
          r_guard  <= w_guard8;
          r_guard4 <= w_guard4;
          r_mask8  <= w_guard8;
          r_mask4  <= w_guard4;
        end
        S_EMIT8: begin
          if (data_o_valid && data_o_ready) r_mask8[w_hi8] <= 1'b0;
        end
        S_EMIT4: begin
          if (data_o_valid && data_o_ready) begin
            r_mask4 <= w_rest4 & ~(LANES'(1) << w_hi4b);
          end else if (r_mask4 == '0 && !w_last) begin
            if (r_count_w == 8'd0) begin
              r_count_w <= r_w_num - 8'd1;
              r_count_h <= r_count_h - 8'd1;
            end else begin
              r_count_w <= r_count_w - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/write_back_packer.md
WRITE_BACK_PACKER -- requirements
Module: write_back_packer

Interface
REQ-001 Parameter LANES, default 6: psum lanes per window.
REQ-002 Parameter PSUM_W, default PSUM_WIDTH from diff_demo_pkg: signed psum width.
REQ-003 Parameter ADDR_W, default $clog2(FM_GUARD_GEN_PSUM_BUF_DEPTH): psum buffer address width.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- ctrl_valid, in, 1, job request.
- ctrl_ready, out, 1, idle and able to accept a job.
- ctrl_finish, out, 1, one-cycle job-done pulse.
- cfg_w_num / cfg_h_num / cfg_w_cut, in, 8 each, windows per row / rows / address skip at end of row.
- cfg_is_diff, in, 1, diff mode.
- rd_en, out, 1, psum buffer read strobe.
- addr_o, out, ADDR_W, psum buffer read address.
- data_i, in, LANES*PSUM_W, psum lanes (lane LANES-1 in the MSBs).
- guard_o, out, LANES, 8-bit nonzero map.
- guard4_o, out, LANES, 4-bit nonzero map (diff mode only).
- guard_o_valid, out, 1, guard handshake valid.
- guard_o_ready, in, 1, guard handshake ready.
- data_o, out, 8, output byte.
- data_o_packed, out, 1, data_o holds two nibbles.
- data_o_valid, out, 1, data handshake valid.
- data_o_ready, in, 1, data handshake ready.

Function
REQ-005 Job accept: a job is accepted when ctrl_valid&&ctrl_ready; the block latches cfg_*; ctrl_ready drops the next cycle.
REQ-006 ctrl_ready returns to 1 in the cycle after the ctrl_finish pulse.
REQ-007 FSM states: IDLE, READ, LOAD, GUARD, EMIT8, EMIT4, FIN.
REQ-008 FSM transitions:
- IDLE -> READ on accept.
- READ -> LOAD.
- LOAD -> GUARD.
- GUARD -> EMIT8 on handshake.
- EMIT8 -> EMIT4 when its mask is empty.
- EMIT4 -> READ, or -> FIN after the last window.
- FIN -> IDLE, with ctrl_finish=1 in FIN.
REQ-009 READ: rd_en=1 for exactly one cycle; data_i is valid in the following cycle (LOAD), when all lanes are captured.
REQ-010 Per-lane value: negative -> 0; above 255 -> 255; otherwise the low 8 bits.
REQ-011 Non-diff mode: guard_o[i] = (value!=0); guard4_o = 0.
REQ-012 Diff mode: guard_o[i] = (value[7:4]!=0); guard4_o[i] = (value!=0 && value[7:4]==0).
REQ-013 GUARD: holds guard_o/guard4_o stable with guard_o_valid=1 until guard_o_ready; an all-zero window still emits its guard, then skips to EMIT4 with nothing sent.
REQ-014 EMIT8: sends one byte per data handshake for each set guard_o bit, highest lane first; data_o_packed=0.
REQ-015 EMIT4: sends guard4_o lanes two per byte, highest lane first.
- First lane of the pair -> data_o[7:4], second -> data_o[3:0].
- An odd leftover is padded with low nibble 0.
- data_o_packed=1.
REQ-016 data_o and data_o_packed hold stable while data_o_valid && !data_o_ready; data_o_valid never drops without a handshake.
REQ-017 addr_o:
- Starts at 0 on accept.
- After each window read: +1, or +cfg_w_cut+1 when the window is the last in its row.
- Wraps modulo 2^ADDR_W.
REQ-018 Counters: count_w counts w_num-1..0 and reloads at the end of a row; count_h decrements per row; the last window is count_w==0 && count_h==0.
REQ-019 cfg_w_num==0 or cfg_h_num==0: no reads; IDLE -> FIN directly, ctrl_finish one cycle after accept +1.
REQ-020 ctrl_valid while busy is ignored; cfg_* changes while busy have no effect.
REQ-021 Outputs are 0 whenever not in their active state: rd_en, guard_o_valid, data_o_valid, data_o, guard_o, guard4_o, data_o_packed.

Reset
REQ-022 Reset values:
- state=IDLE, ctrl_ready=1.
- ctrl_finish=0, rd_en=0, addr_o=0.
- All valids=0, data_o=0, guard_o=0, guard4_o=0, data_o_packed=0.
- Counters and lane registers=0.
REQ-023 Reset asserted mid-job aborts immediately with no ctrl_finish; the first job after release behaves as if from power-up.

Structure
REQ-024 diff_demo_pkg holds PSUM_WIDTH, FM_GUARD_GEN_PSUM_BUF_DEPTH and the wbp_state_t enum.
REQ-025 One sub-module, wbp_lane_quant: per-lane ReLU/saturation and guard bit generation (combinational), instantiated LANES times via generate.
REQ-026 Highest-set-bit select for EMIT8/EMIT4 is a parametrised priority encoder inside the top module.

Verification
REQ-027 Non-diff, w=2, h=1, lanes {0,5,-3,300,0,7} (lane5..0):
- guard_o=6'b010101.
- Bytes 5, 255, 7 with packed=0.
- ctrl_finish after the second window.
REQ-028 Diff, one window, lanes {0x23,0x04,0,0x09,0x30,0x01}:
- guard_o=6'b100010, guard4_o=6'b010101.
- Bytes 0x23, 0x30, then packed 0x49, 0x10.
REQ-029 All-zero window: guard 0 handshake, no data bytes, next READ follows.
REQ-030 Backpressure: data_o_ready and guard_o_ready randomly low 50%; outputs stable while stalled; byte stream identical to the no-stall run.
REQ-031 Address: w=3, h=2, cut=4 gives addr sequence 0,1,2,7,8,9; cfg_h_num=0 gives ctrl_finish with zero rd_en pulses.
REQ-032 Reset asserted during EMIT4: all outputs at reset values the same cycle; a new job after release completes correctly.
